event_encoder_8x3: RTL and testbench
====================================

Name: event_encoder_8x3

Overview:
- Sequential 8-to-3 encoder; the inverse of decoder_3x8.
- Captures event pulses on an 8-bit input vector into a pending register.
- Emits one encoded index per accepted event over a valid/ready output handshake.
- Sits between event-producing logic (decoded one-hot strobes, button/interrupt lines) and any consumer that wants a 3-bit event index stream.

Parameters:
- WIDTH, 8: number of event inputs; must equal 2**IDX_W.
- IDX_W, 3: width of the encoded index output.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- enable  input  1  capture enable; when 0, in_i is ignored but pending events still drain.
- in_i  input  WIDTH  event vector; each high bit sampled at a rising edge is one event.
- out_o  output  IDX_W  encoded index of the presented event.
- valid_o  output  1  out_o holds a valid index.
- ready_i  input  1  consumer accepts out_o this cycle when valid_o=1.
- pending_o  output  1  OR of the pending register.
- overflow_o  output  1  one-cycle pulse: an event was dropped.

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - pending=0, out_o=0, valid_o=0, overflow_o=0, priority pointer=0.
  - Any held or pending events are discarded, including mid-transfer.
- Slot free condition: slot_free = !valid_o | ready_i.
- Selection:
  - When slot_free=1 and pending!=0, pick bit s of pending using the priority rule.
  - Next edge: out_o<=s, valid_o<=1, pending bit s cleared.
  - When slot_free=1 and pending==0: valid_o<=0 and out_o holds its last value.
- Hold rule: while valid_o=1 and ready_i=0, out_o and valid_o stay stable.
- Capture: each edge, pending <= (pending & ~clear_mask) | (enable ? in_i : 0).
  - Set wins over clear on the same bit in the same cycle, so the bit stays pending as a new event.
- Overflow:
  - Condition: enable=1, in_i[b]=1, pending[b]=1, and b is not being cleared this cycle.
  - Response: the event is dropped; overflow_o=1 for exactly the next cycle.
  - Multiple simultaneous drops produce a single pulse.
- Latency:
  - An event sampled at edge k sets pending after edge k.
  - With the slot free and no higher-priority bits pending, valid_o/out_o appear after edge k+1 (2-cycle latency).
- Throughput: one index per cycle with ready_i held high.
- Default priority: fixed, lowest set index wins.
- pending_o: combinational OR of the registered pending vector.
- Simultaneous events: several bits set in one cycle are all captured and emitted one per accepted transfer in priority order; none are lost.
- Wrap-around: index arithmetic is modulo WIDTH (relevant only with round-robin).
- Pipeline: no combinational path from in_i to any output; ready_i affects only registered state.

Optional Feature:
- Macro: EVENT_ENC_ROUND_ROBIN_EN.
- Defined:
  - A pointer register p (IDX_W bits, reset 0) is updated to (s+1) mod WIDTH on each selection.
  - Selection searches pending starting at index p upward with wrap-around, so no input can starve another.
- Undefined: fixed lowest-index priority and no pointer register.

Test Plan:
1. Reset then idle: rst_i=1 for 2 cycles, then enable=1, in_i=0 for 10 cycles -> valid_o=0, out_o=0, pending_o=0, overflow_o=0 throughout.
2. Single event: enable=1, in_i=8'b0010_0000 for one cycle, ready_i=1 -> exactly one cycle of valid_o=1, out_o=3'd5, 2 cycles after the sample; pending_o returns to 0.
3. Burst and priority: in_i=8'b1000_1010 for one cycle, ready_i=1 -> out_o sequence 1, 3, 7 on consecutive cycles with valid_o=1.
   - With EVENT_ENC_ROUND_ROBIN_EN and pointer=4 the sequence is 7, 1, 3.
4. Backpressure: hold ready_i=0 while in_i=8'b0000_0101 -> valid_o=1, out_o=0 stable.
   - Raise ready_i -> next cycle out_o=2; then valid_o drops.
5. Overflow and enable gating: with bit 2 pending and ready_i=0, pulse in_i=8'b0000_0100 -> overflow_o=1 for one cycle.
   - Same pulse with enable=0 -> no overflow, no new event.
6. Reset mid-operation: pending=8'hFF, valid_o=1, assert rst_i for 1 cycle -> next cycle valid_o=0, pending_o=0, and no indices are emitted afterwards.

Source files
------------

// File: rtl/event_encoder_8x3.sv
// event_encoder_8x3 -- sequential 8-to-3 event encoder (inverse of decoder_3x8).
//
// Each high bit of in_i sampled at a rising edge (while enable=1) is one event.
// Events collect in a pending register and are emitted one per accepted
// transfer as an encoded index on a valid/ready handshake.
//
// Ports:
//   clk_i       in   1      system clock, rising edge
//   rst_i       in   1      synchronous reset, active-high
//   enable      in   1      capture enable; pending events still drain when 0
//   in_i        in   WIDTH  event vector
//   out_o       out  IDX_W  encoded index of the presented event
//   valid_o     out  1      out_o holds a valid index
//   ready_i     in   1      consumer accepts out_o this cycle when valid_o=1
//   pending_o   out  1      OR of the pending register
//   overflow_o  out  1      one-cycle pulse: at least one event was dropped
//
// Build option:
//   EVENT_ENC_ROUND_ROBIN_EN  defined   -> round-robin selection via a pointer
//                                          register advanced past each pick
//                             undefined -> fixed priority, lowest index wins
//
// WIDTH must equal 2**IDX_W so that index arithmetic wraps modulo WIDTH.

module event_encoder_8x3 #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable,
    input  logic [WIDTH-1:0] in_i,
    output logic [IDX_W-1:0] out_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             pending_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;

    logic [IDX_W-1:0] search_base;
    logic             slot_free;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             take;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] captured;

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign search_base = ptr_q;
`else
    assign search_base = '0;
`endif

    // Output register may be refilled when empty or being consumed this cycle.
    assign slot_free = !valid_q || ready_i;

    // Scan pending starting at search_base; the IDX_W-bit sum wraps modulo WIDTH.
    always_comb begin : select_p
        logic [IDX_W-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = search_base + IDX_W'(i);
            if (!sel_found && pending_q[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    assign take = slot_free && sel_found;

    // Output slot next state: load a new index, go idle, or hold under backpressure.
    always_comb begin : slot_p
        out_d      = out_q;
        valid_d    = valid_q;
        clear_mask = '0;
        if (slot_free) begin
            valid_d = sel_found;
            if (sel_found) begin
                out_d               = sel_idx;
                clear_mask[sel_idx] = 1'b1;
            end
        end
    end

    assign captured = enable ? in_i : '0;

    // A bit being cleared and re-set in the same cycle stays pending as a new
    // event; only a set onto a bit that remains pending is a drop.
    assign pending_d  = (pending_q & ~clear_mask) | captured;
    assign overflow_d = |(captured & pending_q & ~clear_mask);

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    assign ptr_d = take ? (sel_idx + IDX_W'(1)) : ptr_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q  <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
            ptr_q      <= '0;
`endif
        end else begin
            pending_q  <= pending_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign out_o      = out_q;
    assign valid_o    = valid_q;
    assign pending_o  = |pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_event_encoder_8x3.sv
// Self-checking bench for event_encoder_8x3: directed vector table, a
// round-robin/priority hand sequence, then random traffic against a model.

module tb_event_encoder_8x3;

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] in_v;
    logic [2:0] out_v;
    logic       valid;
    logic       rdy;
    logic       pend;
    logic       ovf;

    int n_chk  = 0;
    int n_fail = 0;

    event_encoder_8x3 #(.WIDTH(8), .IDX_W(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable    (en),
        .in_i      (in_v),
        .out_o     (out_v),
        .valid_o   (valid),
        .ready_i   (rdy),
        .pending_o (pend),
        .overflow_o(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       rst;
        bit       en;
        bit [7:0] in;
        bit       rdy;
        bit       ev;
        bit [2:0] eo;
        bit       ep;
        bit       eovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit e, input bit [7:0] i, input bit rd,
                       input bit ev, input int eo, input bit ep, input bit eovf);
        vec_t v;
        v.rst = r; v.en = e; v.in = i; v.rdy = rd;
        v.ev = ev; v.eo = 3'(eo); v.ep = ep; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock and return once outputs have settled.
    task automatic cycle(input bit r, input bit e, input bit [7:0] i, input bit rd);
        rst = r; en = e; in_v = i; rdy = rd;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit [7:0] m_pend;
    bit       m_valid;
    int       m_out;
    bit       m_ovf;
    int       m_ptr;

    function automatic int find_first(input bit [7:0] p, input int start);
        for (int k = 0; k < 8; k++)
            if (p[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit [7:0] i, input bit rd);
        bit [7:0] taken;
        bit [7:0] nxt;
        int       s;
        if (r) begin
            m_pend = '0; m_valid = 0; m_out = 0; m_ovf = 0; m_ptr = 0;
            return;
        end
        taken = '0;
        if (!m_valid || rd) begin
            s = find_first(m_pend, RR ? m_ptr : 0);
            if (s >= 0) begin
                m_out    = s;
                m_valid  = 1;
                taken[s] = 1'b1;
                m_ptr    = (s + 1) % 8;
            end else begin
                m_valid = 0;
            end
        end
        m_ovf = 0;
        for (int b = 0; b < 8; b++) begin
            nxt[b] = m_pend[b] && !taken[b];
            if (e && i[b]) begin
                if (nxt[b]) m_ovf = 1;
                else        nxt[b] = 1'b1;
            end
        end
        m_pend = nxt;
    endtask

    initial begin
        bit       r, e, rd;
        bit [7:0] iv;
        int       exp_seq[3];

        rst = 1'b1; en = 1'b0; in_v = '0; rdy = 1'b0;

        // 1: reset then idle
        add(1,0,8'h00,1, 0,0,0,0);
        add(1,0,8'h00,1, 0,0,0,0);
        for (int k = 0; k < 10; k++) add(0,1,8'h00,1, 0,0,0,0);
        // 2: single event, two-cycle latency
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h20,1, 0,0,1,0);
        add(0,1,8'h00,1, 1,5,0,0);
        add(0,1,8'h00,1, 0,5,0,0);
        add(0,1,8'h00,1, 0,5,0,0);
        // 3: burst drained in priority order
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h8A,1, 0,0,1,0);
        add(0,1,8'h00,1, 1,1,1,0);
        add(0,1,8'h00,1, 1,3,1,0);
        add(0,1,8'h00,1, 1,7,0,0);
        add(0,1,8'h00,1, 0,7,0,0);
        // 4: backpressure
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h05,0, 0,0,1,0);
        for (int k = 0; k < 4; k++) add(0,1,8'h00,0, 1,0,1,0);
        add(0,1,8'h00,1, 1,2,0,0);
        add(0,1,8'h00,1, 0,2,0,0);
        // 5: overflow and enable gating
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h01,0, 0,0,1,0);
        add(0,1,8'h04,0, 1,0,1,0);
        add(0,1,8'h04,0, 1,0,1,1);
        add(0,1,8'h00,0, 1,0,1,0);
        add(0,0,8'h04,0, 1,0,1,0);
        add(0,0,8'h00,0, 1,0,1,0);
        add(0,1,8'h00,1, 1,2,0,0);
        add(0,1,8'h00,1, 0,2,0,0);
        add(0,0,8'h10,1, 0,2,0,0);
        add(0,0,8'h00,1, 0,2,0,0);
        // set wins over clear on the bit being emitted
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h01,1, 0,0,1,0);
        add(0,1,8'h01,1, 1,0,1,0);
        add(0,1,8'h00,1, 1,0,0,0);
        add(0,1,8'h00,1, 0,0,0,0);
        // several drops in one cycle give one pulse
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'h0F,0, 0,0,1,0);
        add(0,1,8'h0F,0, 1,0,1,1);
        add(0,1,8'h00,0, 1,0,1,0);
        // 6: reset mid-operation
        add(1,0,8'h00,1, 0,0,0,0);
        add(0,1,8'hFF,0, 0,0,1,0);
        add(0,1,8'h00,0, 1,0,1,0);
        add(1,1,8'hFF,0, 0,0,0,0);
        for (int k = 0; k < 4; k++) add(0,1,8'h00,1, 0,0,0,0);

        #2;
        foreach (tbl[n]) begin
            cycle(tbl[n].rst, tbl[n].en, tbl[n].in, tbl[n].rdy);
            chk($sformatf("vec%0d valid", n), int'(valid), int'(tbl[n].ev));
            chk($sformatf("vec%0d out",   n), int'(out_v), int'(tbl[n].eo));
            chk($sformatf("vec%0d pend",  n), int'(pend),  int'(tbl[n].ep));
            chk($sformatf("vec%0d ovf",   n), int'(ovf),   int'(tbl[n].eovf));
        end

        // Priority order after index 3 was emitted (pointer at 4 in round-robin)
        if (RR) exp_seq = '{7, 1, 3};
        else    exp_seq = '{1, 3, 7};
        cycle(1,0,8'h00,1);
        cycle(0,1,8'h08,1);
        cycle(0,1,8'h00,1);
        chk("prio first3", int'(out_v), 3);
        cycle(0,1,8'h8A,1);
        chk("prio idle", int'(valid), 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0,1,8'h00,1);
            chk($sformatf("prio valid%0d", k), int'(valid), 1);
            chk($sformatf("prio out%0d", k), int'(out_v), exp_seq[k]);
        end
        cycle(0,1,8'h00,1);
        chk("prio drained", int'(valid), 0);

        // Random traffic against the model
        model_step(1, 0, 8'h00, 1);
        cycle(1,0,8'h00,1);
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 3) != 0);
            iv = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) iv = '0;
            rd = ($urandom_range(0, 3) != 0);
            model_step(r, e, iv, rd);
            cycle(r, e, iv, rd);
            chk("rnd valid", int'(valid), int'(m_valid));
            chk("rnd pend",  int'(pend),  int'(m_pend != 0));
            chk("rnd ovf",   int'(ovf),   int'(m_ovf));
            if (m_valid) chk("rnd out", int'(out_v), m_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
